// File: rtl/imm_pkg.sv
// Shared immediate-format encoding and FIFO sizing for the immediate decode stage.
package imm_pkg;

   localparam int unsigned FMT_W      = 3;
   localparam int unsigned FIFO_DEPTH = 2;

   typedef enum logic [FMT_W-1:0] {
      FMT_I = 3'd0,
      FMT_S = 3'd1,
      FMT_B = 3'd2,
      FMT_U = 3'd3,
      FMT_J = 3'd4,
      FMT_Z = 3'd5
   } fmt_e;

   function automatic logic fmt_is_legal(input logic [FMT_W-1:0] f);
      return f <= FMT_Z;
   endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream/downstream handshake bundle for imm_decode_stage.
interface imm_decode_stage_if
   import imm_pkg::*;
#(
   parameter int unsigned XLEN = 32
);

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;
   logic [FMT_W-1:0] fmt;
   logic [XLEN-1:0]  pc;

   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  target;
   logic             illegal_fmt;

   modport master (
      output in_valid, instr, fmt, pc, out_ready,
      input  in_ready, out_valid, imm, target, illegal_fmt
   );

   modport slave (
      input  in_valid, instr, fmt, pc, out_ready,
      output in_ready, out_valid, imm, target, illegal_fmt
   );

endinterface

// File: rtl/imm_decode_stage_extract.sv
// Combinational RISC-V immediate extraction; illegal formats yield zero.
module imm_extract
   import imm_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]      instr,
   input  logic [FMT_W-1:0] fmt,
   output logic [XLEN-1:0]  imm,
   output logic             illegal
);

   logic [31:0] raw;
   logic        unused_opcode;

   assign unused_opcode = ^instr[6:0];

   // Every format is first built as a 32-bit value; Z keeps bit 31 clear, so one
   // signed widening covers both sign and zero extension.
   always_comb begin
      raw     = '0;
      illegal = 1'b0;
      case (fmt_e'(fmt))
         FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   raw = {instr[31:12], 12'h000};
         FMT_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         FMT_Z:   raw = {27'd0, instr[19:15]};
         default: illegal = 1'b1;
      endcase
      imm = XLEN'(signed'(raw));
   end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: extract + optional pc add, buffered in a 2-entry FIFO.
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned PC_ADD = 1
) (
   input logic               clk,
   input logic               reset,
   imm_decode_stage_if.slave bus
);

   localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

   logic [XLEN-1:0] ext_imm;
   logic [XLEN-1:0] ext_tgt;
   logic            ext_ill;

   logic [XLEN-1:0] imm_q [FIFO_DEPTH];
   logic [XLEN-1:0] tgt_q [FIFO_DEPTH];
   logic            ill_q [FIFO_DEPTH];

   logic [1:0]      count;
   logic            wr_ptr;
   logic            rd_ptr;
   logic            push;
   logic            pop;
   logic            not_empty;

   imm_extract #(
      .XLEN (XLEN)
   ) u_extract (
      .instr   (bus.instr),
      .fmt     (bus.fmt),
      .imm     (ext_imm),
      .illegal (ext_ill)
   );

   generate
      if (PC_ADD != 0) begin : g_pc_add
         assign ext_tgt = bus.pc + ext_imm;
      end else begin : g_no_pc_add
         assign ext_tgt = '0;
      end
   endgenerate

   assign not_empty = (count != 2'd0);
   assign push      = bus.in_valid && bus.in_ready;
   assign pop       = not_empty && bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage is left unreset; empty-FIFO outputs are forced to zero below.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         imm_q[wr_ptr] <= ext_imm;
         tgt_q[wr_ptr] <= ext_tgt;
         ill_q[wr_ptr] <= ext_ill;
      end
   end

   assign bus.in_ready    = (count < DEPTH);
   assign bus.out_valid   = not_empty;
   assign bus.imm         = not_empty ? imm_q[rd_ptr] : '0;
   assign bus.target      = not_empty ? tgt_q[rd_ptr] : '0;
   assign bus.illegal_fmt = not_empty ? ill_q[rd_ptr] : 1'b0;

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, output datapath width; legal values 32 and 64.
REQ-002 Parameter PC_ADD, default 1, when 1 the target output is computed, when 0 target is tied to zero.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream presents instr/fmt/pc.
REQ-006 in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-007 instr  input  32  raw RISC-V instruction word.
REQ-008 fmt  input  3  immediate format: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 6-7 illegal.
REQ-009 pc  input  XLEN  address of instr.
REQ-010 out_valid  output  1  entry available downstream.
REQ-011 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-012 imm  output  XLEN  extended immediate.
REQ-013 target  output  XLEN  pc + imm, modulo 2^XLEN.
REQ-014 illegal_fmt  output  1  entry carried fmt 6 or 7.

Function
REQ-015 Extraction SHALL be: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); U = sext({instr[31:12],12'b0}); J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); Z = zext(instr[19:15]); sign extension from instr[31] to XLEN.
REQ-016 Illegal fmt SHALL produce imm = 0, target = pc, illegal_fmt = 1; no other effect.
REQ-017 Stage SHALL hold a 2-entry FIFO of {imm, target, illegal_fmt}; extraction and pc add occur before the write, so outputs come from registers only.
REQ-018 Latency SHALL be 1 cycle: entry accepted at edge N is out_valid from edge N onward (visible cycle N+1) when FIFO was empty.
REQ-019 in_ready SHALL equal (count < 2) and depend only on registered state, not on out_ready.
REQ-020 out_valid SHALL equal (count > 0); imm/target/illegal_fmt present the head entry and SHALL hold stable while out_valid && !out_ready.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order, including at count = 1 and count = 2 (push at 2 impossible since in_ready = 0).
REQ-022 Entries SHALL exit in acceptance order; no entry dropped or duplicated.
REQ-023 Read and write pointers are 1 bit each and SHALL wrap 1->0.
REQ-024 When out_valid = 0, imm, target, illegal_fmt SHALL read 0.

Reset
REQ-025 reset SHALL set count, pointers, out_valid, imm, target, illegal_fmt to 0 and in_ready to 1 on the next edge.
REQ-026 reset asserted mid-operation SHALL discard all buffered entries; a handshake in the reset cycle is ignored.

Structure
REQ-027 Package imm_pkg SHALL hold the fmt enum (FMT_I..FMT_Z), FMT_W = 3, and the FIFO depth constant 2.
REQ-028 One combinational sub-module imm_extract (instr, fmt -> imm, illegal) SHALL implement REQ-015/016, parametrised by XLEN.

Verification
REQ-029 XLEN=32, fmt=J, instr=0x0080006F, pc=0x100 -> imm=0x00000008, target=0x00000108, one cycle later.
REQ-030 fmt=B, instr=0xFE000EE3, pc=0x100 -> imm=0xFFFFFFFC, target=0x000000FC; fmt=S, instr=0xFE112C23 -> imm=0xFFFFFFF8.
REQ-031 XLEN=64, fmt=U, instr=0x800000B7 -> imm=0xFFFFFFFF80000000; fmt=I, instr=0xFFF00093 -> imm=0xFFFFFFFFFFFFFFFF; fmt=Z, instr=0x000FD073 -> imm=0x1F.
REQ-032 out_ready=0, in_valid=1 for 3 cycles with I-immediates 1,2,3 -> in_ready=0 after 2 accepted, third held; raise out_ready -> outputs 1,2,3 in order.
REQ-033 count=1, push and pop in the same cycle for 10 cycles -> count stays 1, out_valid constant 1, values emerge in order.
REQ-034 count=2, assert reset one cycle -> out_valid=0, in_ready=1, imm=0; fmt=7 afterwards -> illegal_fmt=1, imm=0, target=pc.
